// File: rtl/regfile_pkg.sv
// Shared constants, opcode/state types and decode helpers for the 10-bit register file sequencer.
package regfile_pkg;

    localparam int unsigned DATA_W = 10;
    localparam int unsigned ADDR_W = 2;

    // Instruction field positions
    localparam int unsigned OP_MSB = 9;
    localparam int unsigned OP_LSB = 6;
    localparam int unsigned RX_MSB = 5;
    localparam int unsigned RX_LSB = 4;
    localparam int unsigned RY_MSB = 3;
    localparam int unsigned RY_LSB = 2;

    typedef enum logic [3:0] {
        OP_LOAD = 4'b0000,
        OP_COPY = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SUB  = 4'b0011,
        OP_INV  = 4'b0100,
        OP_ADDI = 4'b0110,
        OP_SUBI = 4'b0111
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_IMM  = 3'd1,
        ST_READ = 3'd2,
        ST_WB   = 3'd3,
        ST_FIN  = 3'd4
    } seq_state_e;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_LOAD, OP_COPY, OP_ADD, OP_SUB, OP_INV, OP_ADDI, OP_SUBI: op_legal = 1'b1;
            default: op_legal = 1'b0;
        endcase
    endfunction

    function automatic logic op_sets_flags(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_ADDI, OP_SUBI: op_sets_flags = 1'b1;
            default: op_sets_flags = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/regfile_alu.sv
// Combinational single ALU: result and carry/borrow from two register operands,
// a 2-bit immediate and the opcode.
module regfile_alu #(
    parameter int unsigned DATA_W = regfile_pkg::DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [1:0]        imm,
    input  logic [3:0]        opcode,
    output logic [DATA_W-1:0] result,
    output logic              carry
);
    import regfile_pkg::*;

    logic [DATA_W:0] imm_ext;

    assign imm_ext = {{(DATA_W-1){1'b0}}, imm};

    // For subtraction the extra top bit is the borrow (set when a < b).
    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (opcode)
            OP_COPY: result = b;
            OP_ADD:  {carry, result} = {1'b0, a} + {1'b0, b};
            OP_SUB:  {carry, result} = {1'b0, a} - {1'b0, b};
            OP_INV:  result = ~b;
            OP_ADDI: {carry, result} = {1'b0, a} + imm_ext;
            OP_SUBI: {carry, result} = {1'b0, a} - imm_ext;
            default: ;
        endcase
    end

endmodule

// File: rtl/regfile_sequencer.sv
// Instruction sequencer and ALU datapath driving a 4x10-bit register file.
// Optional REGFILE_SEQ_FLAGS_EN adds FLAG_Z/FLAG_C outputs.
module regfile_sequencer #(
    parameter int unsigned DATA_W = regfile_pkg::DATA_W,
    parameter int unsigned ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic              CLKb,
    input  logic              RSTb,
    input  logic [DATA_W-1:0] INSTR,
    input  logic              VALID,
    output logic              READY,
    input  logic [DATA_W-1:0] Q0,
    input  logic [DATA_W-1:0] Q1,
    output logic              ENR0,
    output logic              ENR1,
    output logic [ADDR_W-1:0] RDA0,
    output logic [ADDR_W-1:0] RDA1,
    output logic              ENW,
    output logic [ADDR_W-1:0] WRA,
    output logic [DATA_W-1:0] D,
    output logic              DONE,
    output logic              ILLEGAL
`ifdef REGFILE_SEQ_FLAGS_EN
    ,
    output logic              FLAG_Z,
    output logic              FLAG_C
`endif
);
    import regfile_pkg::*;

    seq_state_e        state, state_d;
    logic [DATA_W-1:0] ir, ir_d;
    logic [DATA_W-1:0] r, r_d;
    logic              rc, rc_d;
    logic              rdy_en;
    logic              accept;
    logic [3:0]        op;
    logic [ADDR_W-1:0] rx, ry;
    logic [1:0]        imm;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic [1:0]        ir_low_unused;

    assign op            = ir[OP_MSB:OP_LSB];
    assign rx            = ir[RX_MSB:RX_LSB];
    assign ry            = ir[RY_MSB:RY_LSB];
    assign imm           = ir[RY_MSB:RY_LSB];
    assign ir_low_unused = ir[1:0];

    // READY stays low during reset and rises on the first clock edge after release.
    assign READY  = rdy_en && (state == ST_IDLE || state == ST_IMM);
    assign accept = VALID && READY;

    regfile_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a      (Q0),
        .b      (Q1),
        .imm    (imm),
        .opcode (op),
        .result (alu_res),
        .carry  (alu_c)
    );

    always_comb begin
        state_d = state;
        ir_d    = ir;
        r_d     = r;
        rc_d    = rc;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    ir_d = INSTR;
                    if (INSTR[OP_MSB:OP_LSB] == OP_LOAD) begin
                        state_d = ST_IMM;
                    end else if (!op_legal(INSTR[OP_MSB:OP_LSB])) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_IMM: begin
                if (accept) begin
                    r_d     = INSTR;
                    state_d = ST_WB;
                end
            end
            ST_READ: begin
                r_d     = alu_res;
                rc_d    = alu_c;
                state_d = ST_WB;
            end
            ST_WB:   state_d = ST_FIN;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLKb or negedge RSTb) begin
        if (!RSTb) begin
            state  <= ST_IDLE;
            ir     <= '0;
            r      <= '0;
            rc     <= 1'b0;
            rdy_en <= 1'b0;
        end else begin
            state  <= state_d;
            ir     <= ir_d;
            r      <= r_d;
            rc     <= rc_d;
            rdy_en <= 1'b1;
        end
    end

    // All register file controls decode from registered state only.
    always_comb begin
        ENR0    = 1'b0;
        ENR1    = 1'b0;
        RDA0    = '0;
        RDA1    = '0;
        ENW     = 1'b0;
        WRA     = '0;
        D       = '0;
        DONE    = 1'b0;
        ILLEGAL = 1'b0;
        case (state)
            ST_READ: begin
                ENR0 = 1'b1;
                ENR1 = 1'b1;
                RDA0 = rx;
                RDA1 = ry;
            end
            ST_WB: begin
                ENW = 1'b1;
                WRA = rx;
                D   = r;
            end
            ST_FIN: begin
                DONE    = 1'b1;
                ILLEGAL = !op_legal(op);
            end
            default: ;
        endcase
    end

`ifdef REGFILE_SEQ_FLAGS_EN
    logic flag_z, flag_c;

    always_ff @(posedge CLKb or negedge RSTb) begin
        if (!RSTb) begin
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else if (state == ST_WB && op_sets_flags(op)) begin
            flag_z <= (r == '0);
            flag_c <= rc;
        end
    end

    assign FLAG_Z = flag_z;
    assign FLAG_C = flag_c;
`else
    logic rc_unused;
    assign rc_unused = rc;
`endif

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed self-checking bench for regfile_sequencer with a behavioural register file.
module tb_regfile_sequencer;

    logic       CLKb, RSTb, VALID;
    logic [9:0] INSTR;
    wire  [9:0] Q0, Q1;
    logic       READY, ENR0, ENR1, ENW, DONE, ILLEGAL;
    logic [1:0] RDA0, RDA1, WRA;
    logic [9:0] D;
`ifdef REGFILE_SEQ_FLAGS_EN
    logic       FLAG_Z, FLAG_C;
`endif

    logic [9:0] rf [4];
    logic       pre_en;
    logic [1:0] pre_a;
    logic [9:0] pre_d;
    int         ncmp = 0;
    int         nfail = 0;
    logic [5:0] ctrl;

    regfile_sequencer dut (
        .CLKb    (CLKb),
        .RSTb    (RSTb),
        .INSTR   (INSTR),
        .VALID   (VALID),
        .READY   (READY),
        .Q0      (Q0),
        .Q1      (Q1),
        .ENR0    (ENR0),
        .ENR1    (ENR1),
        .RDA0    (RDA0),
        .RDA1    (RDA1),
        .ENW     (ENW),
        .WRA     (WRA),
        .D       (D),
        .DONE    (DONE),
        .ILLEGAL (ILLEGAL)
`ifdef REGFILE_SEQ_FLAGS_EN
        ,
        .FLAG_Z  (FLAG_Z),
        .FLAG_C  (FLAG_C)
`endif
    );

    initial begin
        CLKb = 1'b0;
        forever #5 CLKb = ~CLKb;
    end

    assign ctrl = {READY, ENR0, ENR1, ENW, DONE, ILLEGAL};
    assign Q0 = ENR0 ? rf[RDA0] : 'z;
    assign Q1 = ENR1 ? rf[RDA1] : 'z;

    // Register file model: writes land on the falling edge.
    always @(negedge CLKb) begin
        if (ENW) rf[WRA] <= D;
        else if (pre_en) rf[pre_a] <= pre_d;
    end

    task automatic step;
        @(posedge CLKb);
        #1;
    endtask

    task automatic issue(input logic [9:0] w);
        INSTR = w;
        VALID = 1'b1;
        step();
        VALID = 1'b0;
        INSTR = '0;
    endtask

    task automatic preload(input logic [1:0] a, input logic [9:0] v);
        pre_a  = a;
        pre_d  = v;
        pre_en = 1'b1;
        @(negedge CLKb);
        #1;
        pre_en = 1'b0;
    endtask

    task automatic test_reset;
        RSTb = 1'b0;
        repeat (2) @(posedge CLKb);
        #1;
        ncmp++;
        if (ctrl !== 6'b000000) begin
            $display("FAIL reset_ctrl: got %b want %b", ctrl, 6'b000000); nfail++;
        end
        ncmp++;
        if ({RDA0, RDA1, WRA, D} !== 16'h0000) begin
            $display("FAIL reset_addr_data: got %h want %h", {RDA0, RDA1, WRA, D}, 16'h0000);
            nfail++;
        end
        @(negedge CLKb);
        RSTb = 1'b1;
        #1;
        ncmp++;
        if (READY !== 1'b0) begin
            $display("FAIL reset_ready_before_edge: got %b want 0", READY); nfail++;
        end
        step();
        ncmp++;
        if (ctrl !== 6'b100000) begin
            $display("FAIL reset_release: got %b want %b", ctrl, 6'b100000); nfail++;
        end
    endtask

    task automatic test_load;
        issue(10'h010);
        ncmp++;
        if (ctrl !== 6'b100000) begin
            $display("FAIL load_imm_ctrl: got %b want %b", ctrl, 6'b100000); nfail++;
        end
        issue(10'h2A5);
        ncmp++;
        if (ctrl !== 6'b000100) begin
            $display("FAIL load_wb_ctrl: got %b want %b", ctrl, 6'b000100); nfail++;
        end
        ncmp++;
        if ({WRA, D} !== {2'd1, 10'h2A5}) begin
            $display("FAIL load_wb_data: got %h/%h want 1/2a5", WRA, D); nfail++;
        end
        step();
        ncmp++;
        if (ctrl !== 6'b000010) begin
            $display("FAIL load_fin: got %b want %b", ctrl, 6'b000010); nfail++;
        end
        step();
        ncmp++;
        if (ctrl !== 6'b100000) begin
            $display("FAIL load_idle: got %b want %b", ctrl, 6'b100000); nfail++;
        end
        ncmp++;
        if (rf[1] !== 10'h2A5) begin
            $display("FAIL load_rf: got %h want 2a5", rf[1]); nfail++;
        end
    endtask

    task automatic test_add;
        preload(2'd1, 10'h3FF);
        preload(2'd2, 10'h002);
        issue(10'h098);
        ncmp++;
        if (ctrl !== 6'b011000) begin
            $display("FAIL add_read_ctrl: got %b want %b", ctrl, 6'b011000); nfail++;
        end
        ncmp++;
        if ({RDA0, RDA1} !== {2'd1, 2'd2}) begin
            $display("FAIL add_read_addr: got %0d/%0d want 1/2", RDA0, RDA1); nfail++;
        end
        step();
        ncmp++;
        if ({ENW, WRA, D} !== {1'b1, 2'd1, 10'h001}) begin
            $display("FAIL add_wb: got %b/%h/%h want 1/1/001", ENW, WRA, D); nfail++;
        end
        step();
        ncmp++;
        if (ctrl !== 6'b000010) begin
            $display("FAIL add_fin: got %b want %b", ctrl, 6'b000010); nfail++;
        end
`ifdef REGFILE_SEQ_FLAGS_EN
        ncmp++;
        if ({FLAG_Z, FLAG_C} !== 2'b01) begin
            $display("FAIL add_flags: got %b want 01", {FLAG_Z, FLAG_C}); nfail++;
        end
`endif
        step();
        ncmp++;
        if (rf[1] !== 10'h001) begin
            $display("FAIL add_rf: got %h want 001", rf[1]); nfail++;
        end
    endtask

    task automatic test_sub;
        preload(2'd0, 10'h155);
        issue(10'h0C0);
        ncmp++;
        if ({ENR0, ENR1, RDA0, RDA1} !== 6'b110000) begin
            $display("FAIL sub_read: got %b want 110000", {ENR0, ENR1, RDA0, RDA1}); nfail++;
        end
        step();
        ncmp++;
        if ({ENW, WRA, D} !== {1'b1, 2'd0, 10'h000}) begin
            $display("FAIL sub_wb: got %b/%h/%h want 1/0/000", ENW, WRA, D); nfail++;
        end
        step();
`ifdef REGFILE_SEQ_FLAGS_EN
        ncmp++;
        if ({FLAG_Z, FLAG_C} !== 2'b10) begin
            $display("FAIL sub_flags: got %b want 10", {FLAG_Z, FLAG_C}); nfail++;
        end
`endif
        step();
        ncmp++;
        if (rf[0] !== 10'h000) begin
            $display("FAIL sub_rf: got %h want 000", rf[0]); nfail++;
        end
    endtask

    task automatic test_inv_addi;
        preload(2'd1, 10'h0F0);
        issue(10'h134);
        ncmp++;
        if ({RDA0, RDA1} !== {2'd3, 2'd1}) begin
            $display("FAIL inv_read_addr: got %0d/%0d want 3/1", RDA0, RDA1); nfail++;
        end
        step();
        ncmp++;
        if ({ENW, WRA, D} !== {1'b1, 2'd3, 10'h30F}) begin
            $display("FAIL inv_wb: got %b/%h/%h want 1/3/30f", ENW, WRA, D); nfail++;
        end
        step();
`ifdef REGFILE_SEQ_FLAGS_EN
        ncmp++;
        if ({FLAG_Z, FLAG_C} !== 2'b10) begin
            $display("FAIL inv_flags_hold: got %b want 10", {FLAG_Z, FLAG_C}); nfail++;
        end
`endif
        step();
        issue(10'h1BC);
        step();
        ncmp++;
        if ({ENW, WRA, D} !== {1'b1, 2'd3, 10'h312}) begin
            $display("FAIL addi_wb: got %b/%h/%h want 1/3/312", ENW, WRA, D); nfail++;
        end
        step();
`ifdef REGFILE_SEQ_FLAGS_EN
        ncmp++;
        if ({FLAG_Z, FLAG_C} !== 2'b00) begin
            $display("FAIL addi_flags: got %b want 00", {FLAG_Z, FLAG_C}); nfail++;
        end
`endif
        step();
        ncmp++;
        if (rf[3] !== 10'h312) begin
            $display("FAIL addi_rf: got %h want 312", rf[3]); nfail++;
        end
    endtask

    task automatic test_illegal;
        logic [9:0] words [2];
        words[0] = 10'h3C0;
        words[1] = 10'h140;
        for (int i = 0; i < 2; i++) begin
            issue(words[i]);
            ncmp++;
            if (ctrl !== 6'b000011) begin
                $display("FAIL illegal_fin_%0d: got %b want %b", i, ctrl, 6'b000011); nfail++;
            end
            ncmp++;
            if ({RDA0, RDA1, WRA, D} !== 16'h0000) begin
                $display("FAIL illegal_idle_outs_%0d: got %h want 0000", i,
                         {RDA0, RDA1, WRA, D});
                nfail++;
            end
            step();
            ncmp++;
            if (ctrl !== 6'b100000) begin
                $display("FAIL illegal_after_%0d: got %b want %b", i, ctrl, 6'b100000); nfail++;
            end
        end
    endtask

    task automatic test_stall_reset;
        preload(2'd2, 10'h0AA);
        issue(10'h020);
        for (int i = 0; i < 5; i++) begin
            ncmp++;
            if (ctrl !== 6'b100000) begin
                $display("FAIL stall_imm_%0d: got %b want %b", i, ctrl, 6'b100000); nfail++;
            end
            step();
        end
        issue(10'h123);
        ncmp++;
        if ({ENW, WRA, D} !== {1'b1, 2'd2, 10'h123}) begin
            $display("FAIL stall_wb: got %b/%h/%h want 1/2/123", ENW, WRA, D); nfail++;
        end
        #1;
        RSTb = 1'b0;
        #1;
        ncmp++;
        if (ctrl !== 6'b000000) begin
            $display("FAIL midwb_reset_ctrl: got %b want %b", ctrl, 6'b000000); nfail++;
        end
        @(negedge CLKb);
        #1;
        ncmp++;
        if (rf[2] !== 10'h0AA) begin
            $display("FAIL midwb_no_write: got %h want 0aa", rf[2]); nfail++;
        end
        RSTb = 1'b1;
        step();
        ncmp++;
        if (ctrl !== 6'b100000) begin
            $display("FAIL midwb_release: got %b want %b", ctrl, 6'b100000); nfail++;
        end
    endtask

    initial begin
        VALID  = 1'b0;
        INSTR  = '0;
        pre_en = 1'b0;
        pre_a  = '0;
        pre_d  = '0;
        test_reset();
        test_load();
        test_add();
        test_sub();
        test_inv_addi();
        test_illegal();
        test_stall_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
